step_sequencer: RTL and testbench

//  Upstream feeder for the 8-deep step shift register. Paces beats with a clock-divider

---
 rtl/ddr_pkg.sv | 15 +
 rtl/step_rom.sv | 20 ++
 rtl/step_sequencer.sv | 141 ++++++++++++++
 tb/tb_step_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types and constants for the step-feed path into the 8-deep step shift register.
package ddr_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        PAUSE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    localparam int STEP_W   = 4;
    localparam int SR_DEPTH = 8;

endpackage

// File: rtl/step_rom.sv
// Song ROM: one STEP_W-bit step per address, synchronous read with one cycle of latency.
// The contents come from the ROM_INIT vector.
module step_rom
    import ddr_pkg::*;
#(
    parameter int                             ADDR_W   = 6,
    parameter bit                             USE_FILE = 1'b0,
    parameter string                          ROM_FILE = "song.hex",
    parameter logic [(2**ADDR_W)*STEP_W-1:0]  ROM_INIT = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [STEP_W-1:0] data
);

    always_ff @(posedge clk) begin
        data <= ROM_INIT[addr*STEP_W +: STEP_W];
    end

endmodule

// File: rtl/step_sequencer.sv
// Beat-paced feeder for the step shift register: plays the song ROM one step per beat,
// flushes the register with blank steps, then flags completion.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   PLAY  | issuing ROM steps, one per beat
//   PAUSE | beat counter frozen, resumes into the remembered state
//   DRAIN | issuing blank steps to flush the shift register
//   DONE  | song finished, songDone high until the next start
module step_sequencer
    import ddr_pkg::*;
#(
    parameter int                             BEAT_TICKS   = 12_000_000,
    parameter int                             SONG_LEN     = 64,
    parameter int                             ADDR_W       = 6,
    parameter int                             DRAIN_STEPS  = SR_DEPTH,
    parameter bit                             USE_ROM_FILE = 1'b0,
    parameter string                          ROM_FILE     = "song.hex",
    parameter logic [(2**ADDR_W)*STEP_W-1:0]  ROM_INIT     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pauseTgl,
    output logic              stepEn,
    output logic [STEP_W-1:0] inputStep,
    output logic [ADDR_W-1:0] beatIdx,
    output logic              playing,
    output logic              songDone
);

    localparam int CNT_W = $clog2(BEAT_TICKS);
    localparam int DC_W  = $clog2(DRAIN_STEPS + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(BEAT_TICKS - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(SONG_LEN - 1);
    localparam logic [DC_W-1:0]   DRAIN_LAST = DC_W'(DRAIN_STEPS - 1);

    seq_state_t        state_q, state_d;
    seq_state_t        resume_q, resume_d;
    seq_state_t        post_beat;
    logic [CNT_W-1:0]  cnt_q;
    logic [DC_W-1:0]   drain_cnt_q;
    logic [STEP_W-1:0] rom_data;
    logic              running;
    logic              beat;
    logic              start_ok;

    step_rom #(
        .ADDR_W   (ADDR_W),
        .USE_FILE (USE_ROM_FILE),
        .ROM_FILE (ROM_FILE),
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (beatIdx),
        .data (rom_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            resume_q <= PLAY;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        resume_d  = resume_q;
        post_beat = state_q;
        running   = (state_q == PLAY) || (state_q == DRAIN);
        beat      = running && (cnt_q == CNT_MAX);
        start_ok  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = PLAY;
                end
            end
            PLAY, DRAIN: begin
                if (beat && state_q == PLAY && beatIdx == LAST_IDX) begin
                    post_beat = DRAIN;
                end
                if (beat && state_q == DRAIN && drain_cnt_q == DRAIN_LAST) begin
                    post_beat = DONE;
                end
                state_d = post_beat;
                // A toggle landing on the final drain beat has nothing left to pause.
                if (pauseTgl && post_beat != DONE) begin
                    resume_d = post_beat;
                    state_d  = PAUSE;
                end
            end
            PAUSE: begin
                if (pauseTgl) begin
                    state_d = resume_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            drain_cnt_q <= '0;
            beatIdx     <= '0;
            stepEn      <= 1'b0;
            inputStep   <= '0;
        end else begin
            stepEn <= beat;
            if (start_ok) begin
                cnt_q       <= '0;
                drain_cnt_q <= '0;
                beatIdx     <= '0;
                inputStep   <= '0;
            end else if (running) begin
                cnt_q <= beat ? '0 : cnt_q + CNT_W'(1);
                if (beat && state_q == PLAY) begin
                    inputStep <= rom_data;
                    if (beatIdx != LAST_IDX) begin
                        beatIdx <= beatIdx + ADDR_W'(1);
                    end
                end
                if (beat && state_q == DRAIN) begin
                    inputStep   <= '0;
                    drain_cnt_q <= drain_cnt_q + DC_W'(1);
                end
            end
        end
    end

    assign playing  = (state_q == PLAY) || (state_q == DRAIN);
    assign songDone = (state_q == DONE);

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: table-driven full song, then pause, start-ignore,
// pause-on-last-beat, async reset and minimum-parameter cases.
module tb_step_sequencer;
    import ddr_pkg::*;

    localparam int BT = 4;
    localparam int SL = 3;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          pauseTgl = 1'b0;
    logic          start2 = 1'b0;
    logic          pause2 = 1'b0;
    logic          stepEn, playing, songDone;
    logic [3:0]    inputStep;
    logic [AW-1:0] beatIdx;
    logic          stepEn2, playing2, songDone2;
    logic [3:0]    inputStep2;
    logic [0:0]    beatIdx2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    step_sequencer #(
        .BEAT_TICKS  (BT),
        .SONG_LEN    (SL),
        .ADDR_W      (AW),
        .DRAIN_STEPS (8),
        .ROM_INIT    ({4'h0, 4'hF, 4'h8, 4'h1})
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pauseTgl  (pauseTgl),
        .stepEn    (stepEn),
        .inputStep (inputStep),
        .beatIdx   (beatIdx),
        .playing   (playing),
        .songDone  (songDone)
    );

    step_sequencer #(
        .BEAT_TICKS  (2),
        .SONG_LEN    (1),
        .ADDR_W      (1),
        .DRAIN_STEPS (8),
        .ROM_INIT    ({4'h0, 4'h1})
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .pauseTgl  (pause2),
        .stepEn    (stepEn2),
        .inputStep (inputStep2),
        .beatIdx   (beatIdx2),
        .playing   (playing2),
        .songDone  (songDone2)
    );

    typedef struct {
        logic       st;
        logic       pt;
        logic       exp_en;
        logic [3:0] exp_step;
        logic [1:0] exp_idx;
        logic       exp_play;
        logic       exp_done;
    } vec_t;

    vec_t vecs [47];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic pt);
        start    = st;
        pauseTgl = pt;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        pauseTgl = 1'b0;
    endtask

    // Runs until the next stepEn (bounded) and checks gap and issued step.
    task automatic wait_beat(input int exp_gap, input logic [3:0] exp_step, input string tag);
        int n;
        n = 0;
        do begin
            cyc(1'b0, 1'b0);
            n++;
        end while (!stepEn && n < exp_gap + 6);
        check({tag, " gap"}, n, exp_gap);
        check({tag, " step"}, inputStep, exp_step);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int k;

        repeat (2) @(negedge clk);
        check("rst stepEn", stepEn, 0);
        check("rst inputStep", inputStep, 0);
        check("rst beatIdx", beatIdx, 0);
        check("rst playing", playing, 0);
        check("rst songDone", songDone, 0);
        reset = 1'b0;
        @(negedge clk);

        // Full song: beats at 4, 8, 12, drain beats at 16..44, DONE from 44.
        for (int c = 0; c < 47; c++) begin
            k = c / 4;
            vecs[c].st       = (c == 0);
            vecs[c].pt       = 1'b0;
            vecs[c].exp_en   = (c >= 4) && (c <= 44) && (c % 4 == 0);
            vecs[c].exp_step = (k == 1) ? 4'h1 : (k == 2) ? 4'h8 : (k == 3) ? 4'hF : 4'h0;
            vecs[c].exp_idx  = (c < 4) ? 2'd0 : (c < 8) ? 2'd1 : 2'd2;
            vecs[c].exp_play = (c < 44);
            vecs[c].exp_done = (c >= 44);
        end
        for (int i = 0; i < 47; i++) begin
            cyc(vecs[i].st, vecs[i].pt);
            check($sformatf("song c%0d stepEn", i), stepEn, vecs[i].exp_en);
            check($sformatf("song c%0d inputStep", i), inputStep, vecs[i].exp_step);
            check($sformatf("song c%0d beatIdx", i), beatIdx, vecs[i].exp_idx);
            check($sformatf("song c%0d playing", i), playing, vecs[i].exp_play);
            check($sformatf("song c%0d songDone", i), songDone, vecs[i].exp_done);
        end

        // Restart from DONE, then a start while playing must be ignored.
        cyc(1'b1, 1'b0);
        check("replay songDone", songDone, 0);
        check("replay playing", playing, 1);
        check("replay beatIdx", beatIdx, 0);
        check("replay inputStep", inputStep, 0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check("ign c3 stepEn", stepEn, 0);
        cyc(1'b0, 1'b0);
        check("ign c4 stepEn", stepEn, 1);
        check("ign c4 inputStep", inputStep, 4'h1);
        check("ign c4 beatIdx", beatIdx, 1);
        wait_beat(4, 4'h8, "ign beat2");
        check("ign beatIdx", beatIdx, 2);

        // Pause two cycles after the first beat, resume after 20 cycles.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, 1'b0);
        wait_beat(4, 4'h1, "pause beat1");
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check("pause playing", playing, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0);
            if (stepEn) pulses++;
        end
        check("pause pulses", pulses, 0);
        check("pause hold inputStep", inputStep, 4'h1);
        cyc(1'b0, 1'b1);
        check("resume playing", playing, 1);
        wait_beat(2, 4'h8, "resume beat2");
        check("resume beatIdx", beatIdx, 2);

        // Pause on the same edge as the last song beat; resume lands in DRAIN.
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check("lastpause stepEn", stepEn, 1);
        check("lastpause inputStep", inputStep, 4'hF);
        check("lastpause playing", playing, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0);
            if (stepEn) pulses++;
        end
        check("lastpause pulses", pulses, 0);
        check("lastpause hold inputStep", inputStep, 4'hF);
        cyc(1'b0, 1'b1);
        check("drain resume playing", playing, 1);
        wait_beat(4, 4'h0, "drain beat1");
        check("drain songDone", songDone, 0);

        // Asynchronous reset between edges, mid-DRAIN.
        #2;
        reset = 1'b1;
        #1;
        check("async stepEn", stepEn, 0);
        check("async inputStep", inputStep, 0);
        check("async beatIdx", beatIdx, 0);
        check("async playing", playing, 0);
        check("async songDone", songDone, 0);
        #1;
        reset = 1'b0;
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0);
            if (stepEn) pulses++;
        end
        check("post-reset pulses", pulses, 0);
        check("post-reset playing", playing, 0);

        // BEAT_TICKS=2, SONG_LEN=1: beat at 2 with step 1, drain beats 4..18, DONE at 18.
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        check("min c0 playing", playing2, 1);
        for (int c = 1; c <= 20; c++) begin
            cyc(1'b0, 1'b0);
            check($sformatf("min c%0d stepEn", c), stepEn2, (c % 2 == 0) && (c >= 2) && (c <= 18));
            check($sformatf("min c%0d inputStep", c), inputStep2, (c == 2 || c == 3) ? 4'h1 : 4'h0);
            check($sformatf("min c%0d beatIdx", c), beatIdx2, 0);
            check($sformatf("min c%0d songDone", c), songDone2, c >= 18);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
